// File: rtl/clk_rst_seq_pkg.sv
// Shared types and defaults for the clock-enable / reset sequencer.
// Timeout feature: CLK_RST_SEQUENCER_TIMEOUT_EN.
package clk_rst_seq_pkg;

    localparam int ST_W      = 3;
    localparam int DIV_W_DEF = 4;
    localparam int CNT_W_DEF = 8;
    localparam int TMO_W     = 32;

    typedef enum logic [ST_W-1:0] {
        S_RESET  = 3'd0,
        S_HOLD   = 3'd1,
        S_RUN    = 3'd2,
        S_HALTED = 3'd3,
        S_DONE   = 3'd4
    } seq_state_t;

endpackage

// File: rtl/clk_rst_sequencer_divider.sv
// Programmable-ratio enable divider; period is div_q+1 cycles.
// div_cfg is resampled only at period boundaries or on restart.
module clk_en_divider
    import clk_rst_seq_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             restart,
    input  logic [DIV_W-1:0] div_cfg,
    output logic             clk_en_raw,
    output logic             period_last
);

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_q;

    assign clk_en_raw  = (div_cnt == '0);
    assign period_last = (div_cnt == div_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            div_q   <= '0;
        end else if (restart || period_last) begin
            div_cnt <= '0;
            div_q   <= div_cfg;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/clk_rst_sequencer.sv
// Core reset stretcher, clock-enable generator and halt handshake.
// Optional cycle-budget timeout: CLK_RST_SEQUENCER_TIMEOUT_EN.
module clk_rst_sequencer
    import clk_rst_seq_pkg::*;
#(
    parameter int RST_CYCLES = 16,
    parameter int DIV_W      = DIV_W_DEF,
    parameter int CNT_W      = CNT_W_DEF
`ifdef CLK_RST_SEQUENCER_TIMEOUT_EN
    ,
    parameter logic [TMO_W-1:0] TIMEOUT_CYCLES = 32'd1000000
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] div_cfg,
    input  logic             halt_req,
    output logic             rst_core,
    output logic             clk_en,
    output logic             run,
    output logic             halt_ack,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    seq_state_t       state;
    seq_state_t       state_nxt;
    logic [CNT_W-1:0] stretch_cnt;
    logic             restart;
    logic             clk_en_raw;
    logic             period_last;
    logic             expire;

    clk_en_divider #(
        .DIV_W(DIV_W)
    ) u_div (
        .clk        (clk),
        .rst        (rst),
        .restart    (restart),
        .div_cfg    (div_cfg),
        .clk_en_raw (clk_en_raw),
        .period_last(period_last)
    );

    // Every entry into RUN restarts the period so the first cycle pulses.
    assign restart = (state_nxt == S_RUN) && (state != S_RUN);
    assign clk_en  = (state == S_RUN) && clk_en_raw;

`ifdef CLK_RST_SEQUENCER_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (clk_en) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign expire = clk_en && (tmo_cnt == TIMEOUT_CYCLES - 1'b1);
`else
    assign expire  = 1'b0;
    assign timeout = 1'b0;
`endif

    // Saturating count of edges seen with rst low.
    always_ff @(posedge clk) begin
        if (rst) begin
            stretch_cnt <= '0;
        end else if (stretch_cnt != CNT_MAX) begin
            stretch_cnt <= stretch_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_RESET: begin
                state_nxt = (RST_CYCLES == 1) ? S_RUN : S_HOLD;
            end
            S_HOLD: begin
                if (stretch_cnt >= HOLD_LAST) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (expire) begin
                    state_nxt = S_DONE;
                end else if (halt_req && period_last) begin
                    state_nxt = S_HALTED;
                end
            end
            S_HALTED: begin
                if (!halt_req) begin
                    state_nxt = S_RUN;
                end
            end
            S_DONE: begin
                state_nxt = S_DONE;
            end
            default: begin
                state_nxt = S_RESET;
            end
        endcase
        if (rst) begin
            state_nxt = S_RESET;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_RESET;
            rst_core <= 1'b1;
            run      <= 1'b0;
            halt_ack <= 1'b0;
        end else begin
            state    <= state_nxt;
            rst_core <= (state_nxt == S_RESET) ||
                        (state_nxt == S_HOLD);
            run      <= (state_nxt == S_RUN);
            halt_ack <= (state_nxt == S_HALTED);
        end
    end

`ifdef CLK_RST_SEQUENCER_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            timeout <= 1'b0;
        end else begin
            timeout <= (state_nxt == S_DONE);
        end
    end
`endif

endmodule
